// File: rtl/whd_pkg.sv
// rtl/whd_pkg.sv - shared widths, FSM states and Hadamard sign helper for the despreader
package whd_pkg;
  localparam int M     = 8;
  localparam int N     = 16;
  localparam int LOGN  = 4;
  localparam int W_IN  = M + LOGN;
  localparam int W_ACC = M + 2 * LOGN + 1;
  localparam int W_C   = LOGN - 1;

  typedef enum logic [1:0] {IDLE, ACC, FINAL, DONE} state_t;

  // 1 means H[r][k] = -1 (odd popcount of r & k)
  function automatic logic h_sign(input logic [LOGN-1:0] r, input logic [LOGN-1:0] k);
    return ^(r & k);
  endfunction
endpackage

// File: rtl/whd_despread_if.sv
// rtl/whd_despread_if.sv - block-in / block-out handshake bundle of the despreader
interface whd_despread_if;
  import whd_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [N*W_IN-1:0]     y_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*M-1:0]        u_out;
  logic                  sat_flag;

  modport master (
    output in_valid, y_in, out_ready,
    input  in_ready, out_valid, u_out, sat_flag
  );

  modport slave (
    input  in_valid, y_in, out_ready,
    output in_ready, out_valid, u_out, sat_flag
  );
endinterface

// File: rtl/whd_round_sat.sv
// rtl/whd_round_sat.sv - one lane: divide by N with round-half-up, then clamp to signed M bits
module whd_round_sat
  import whd_pkg::*;
(
  input  logic signed [W_ACC-1:0] acc_i,
  output logic        [M-1:0]     u_o,
  output logic                    clip_o
);
  localparam int W_V = W_ACC - LOGN;

  logic signed [W_ACC-1:0] sum;
  logic signed [W_V-1:0]   v;
  logic        [W_V-M:0]   top;

  assign sum = acc_i + W_ACC'(1 << (LOGN - 1));
  assign v   = W_V'(sum >>> LOGN);
  // v fits in M bits only when every bit from the M-1 sign position upward agrees
  assign top    = v[W_V-1:M-1];
  assign clip_o = !((&top) || !(|top));
  assign u_o    = !clip_o ? v[M-1:0]
                : (v[W_V-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}});
endmodule

// File: rtl/whd_despread.sv
// rtl/whd_despread.sv - Walsh-Hadamard despreader, two chip columns per cycle over N/2 cycles
module whd_despread
  import whd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  whd_despread_if.slave  bus
);
  state_t                  state_q;
  logic [W_C-1:0]          c_q;
  logic [N-1:0][W_IN-1:0]  chip_q;
  logic signed [W_ACC-1:0] acc_q [N];
  logic signed [W_ACC-1:0] acc_d [N];
  logic [N-1:0][M-1:0]     u_q;
  logic [N-1:0][M-1:0]     u_d;
  logic [N-1:0]            clip;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    sat_q;
  logic signed [W_IN-1:0]  p;
  logic signed [W_IN-1:0]  q;
  logic signed [W_ACC-1:0] s_ext;
  logic signed [W_ACC-1:0] d_ext;

  assign p     = chip_q[{c_q, 1'b0}];
  assign q     = chip_q[{c_q, 1'b1}];
  assign s_ext = W_ACC'(p) + W_ACC'(q);
  assign d_ext = W_ACC'(p) - W_ACC'(q);

  // Odd rows flip sign between columns 2c and 2c+1, so they see p-q instead of p+q
  always_comb begin
    for (int r = 0; r < N; r++) begin
      acc_d[r] = acc_q[r];
      if (h_sign(LOGN'(r), {c_q, 1'b0}))
        acc_d[r] = acc_q[r] - (((r % 2) == 0) ? s_ext : d_ext);
      else
        acc_d[r] = acc_q[r] + (((r % 2) == 0) ? s_ext : d_ext);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    whd_round_sat u_rs (
      .acc_i  (acc_q[g]),
      .u_o    (u_d[g]),
      .clip_o (clip[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      chip_q      <= '0;
      u_q         <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int r = 0; r < N; r++) acc_q[r] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            chip_q     <= bus.y_in;
            c_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACC;
            for (int r = 0; r < N; r++) acc_q[r] <= '0;
          end
        end
        ACC: begin
          for (int r = 0; r < N; r++) acc_q[r] <= acc_d[r];
          c_q <= c_q + W_C'(1);
          if (c_q == W_C'(N / 2 - 1)) state_q <= FINAL;
        end
        FINAL: begin
          u_q         <= u_d;
          sat_q       <= |clip;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.u_out     = u_q;
  assign bus.sat_flag  = sat_q;
endmodule
